// File: rtl/axis_backoff_ctrl_pkg.sv
// Shared definitions for the half-duplex retransmit controller and the MAC tx path.
package axis_backoff_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX      = 3'd1,
    ST_JAM     = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_DROP    = 3'd4
  } state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Low k bits set: selects the backoff slot count r out of the PRNG word.
  function automatic logic [15:0] backoff_mask(input logic [4:0] k);
    return (16'd1 << k) - 16'd1;
  endfunction

endpackage

// File: rtl/axis_backoff_ctrl_lfsr_prng.sv
// Free-running Galois LFSR; advances every clock and reloads SEED on reset.
module lfsr_prng #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = '1,
  parameter logic [WIDTH-1:0] TAPS  = '1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= SEED;
    else     out <= out[0] ? ((out >> 1) ^ TAPS) : (out >> 1);
  end

endmodule

// File: rtl/axis_backoff_ctrl.sv
// Retransmit controller: jam, truncated binary exponential backoff and replay on collision.
// Handshake: tx_beat is valid&&ready at the replay buffer output; hold forces downstream ready low.
module axis_backoff_ctrl
  import axis_backoff_ctrl_pkg::*;
#(
  parameter int          SLOT_CYCLES   = 128,
  parameter int          JAM_CYCLES    = 8,
  parameter int          MAX_ATTEMPTS  = 16,
  parameter int          BACKOFF_LIMIT = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hace1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_beat,
  input  logic       tx_last,
  input  logic       collision,
  input  logic       replayable,
  output logic       replay,
  output logic       done,
  output logic       hold,
  output logic       jam,
  output logic       drop,
  output logic       tx_ok,
  output logic       tx_abort,
  output logic       late_col,
  output logic [4:0] attempts,
  output state_e     dbg_state
);

  localparam int BO_MAX = ((1 << BACKOFF_LIMIT) - 1) * SLOT_CYCLES;
  localparam int CW     = $clog2(BO_MAX + 1);
  localparam int JW     = (JAM_CYCLES > 1) ? $clog2(JAM_CYCLES) : 1;

  state_e          state;
  logic [JW-1:0]   jam_cnt;
  logic [CW-1:0]   bo_cnt;
  logic            abort_q;
  logic [15:0]     lfsr;
  logic [4:0]      att_next;
  logic [4:0]      k;
  logic [15:0]     r_val;
  logic [CW-1:0]   bo_load;

  lfsr_prng #(
    .WIDTH (16),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_TAPS)
  ) u_prng (
    .clk (clk),
    .rst (rst),
    .out (lfsr)
  );

  assign att_next  = attempts + 5'd1;
  assign k         = (attempts > 5'(BACKOFF_LIMIT)) ? 5'(BACKOFF_LIMIT) : attempts;
  assign r_val     = lfsr & backoff_mask(k);
  assign bo_load   = CW'(r_val) * CW'(SLOT_CYCLES) - CW'(1);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      replay   <= 1'b0;
      done     <= 1'b0;
      hold     <= 1'b0;
      jam      <= 1'b0;
      drop     <= 1'b0;
      tx_ok    <= 1'b0;
      tx_abort <= 1'b0;
      late_col <= 1'b0;
      attempts <= 5'd0;
      jam_cnt  <= '0;
      bo_cnt   <= '0;
      abort_q  <= 1'b0;
    end else begin
      replay   <= 1'b0;
      done     <= 1'b0;
      tx_ok    <= 1'b0;
      tx_abort <= 1'b0;
      late_col <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_beat) begin
            if (tx_last) begin
              done  <= 1'b1;
              tx_ok <= 1'b1;
            end else begin
              state <= ST_TX;
            end
          end
        end
        ST_TX: begin
          // A replayable collision outranks a coincident last beat.
          if (collision && replayable) begin
            attempts <= att_next;
            jam      <= 1'b1;
            hold     <= 1'b1;
            jam_cnt  <= JW'(JAM_CYCLES - 1);
            state    <= ST_JAM;
            if (att_next < 5'(MAX_ATTEMPTS)) begin
              replay  <= 1'b1;
              abort_q <= 1'b0;
            end else begin
              done     <= 1'b1;
              tx_abort <= 1'b1;
              abort_q  <= 1'b1;
            end
          end else begin
            if (collision) late_col <= 1'b1;
            if (tx_beat && tx_last) begin
              done     <= 1'b1;
              tx_ok    <= 1'b1;
              attempts <= 5'd0;
              state    <= ST_IDLE;
            end
          end
        end
        ST_JAM: begin
          if (jam_cnt == '0) begin
            jam <= 1'b0;
            if (abort_q) begin
              hold  <= 1'b0;
              drop  <= 1'b1;
              state <= ST_DROP;
            end else if (r_val == 16'd0) begin
              // Zero slots drawn: resume straight away so no beat lands in a hold-free backoff.
              hold  <= 1'b0;
              state <= ST_TX;
            end else begin
              bo_cnt <= bo_load;
              state  <= ST_BACKOFF;
            end
          end else begin
            jam_cnt <= jam_cnt - JW'(1);
          end
        end
        ST_BACKOFF: begin
          if (bo_cnt == '0) begin
            hold  <= 1'b0;
            state <= ST_TX;
          end else begin
            bo_cnt <= bo_cnt - CW'(1);
          end
        end
        ST_DROP: begin
          if (tx_beat && tx_last) begin
            drop     <= 1'b0;
            attempts <= 5'd0;
            abort_q  <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_backoff_ctrl.sv
// Bench for axis_backoff_ctrl: vector table, frame-level model with backoff prediction, random frames.
module tb_axis_backoff_ctrl;
  import axis_backoff_ctrl_pkg::*;

  localparam int          SLOT = 4;
  localparam int          JAMC = 8;
  localparam int          MAXA = 16;
  localparam int          BLIM = 10;
  localparam logic [15:0] SEED = 16'hace1;
  localparam logic [15:0] POLY = 16'(1 << 15) | 16'(1 << 13) | 16'(1 << 12) | 16'(1 << 10);

  localparam logic [7:0] F_REPLAY = 8'h80;
  localparam logic [7:0] F_DONE   = 8'h40;
  localparam logic [7:0] F_HOLD   = 8'h20;
  localparam logic [7:0] F_JAM    = 8'h10;
  localparam logic [7:0] F_DROP   = 8'h08;
  localparam logic [7:0] F_OK     = 8'h04;
  localparam logic [7:0] F_ABORT  = 8'h02;
  localparam logic [7:0] F_LATE   = 8'h01;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_beat, tx_last, collision, replayable;
  logic       replay, done, hold, jam, drop, tx_ok, tx_abort, late_col;
  logic [4:0] attempts;
  state_e     dbg_state;

  int errors = 0;
  int checks = 0;
  logic [12:0] exp_q[$];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  axis_backoff_ctrl #(
    .SLOT_CYCLES   (SLOT),
    .JAM_CYCLES    (JAMC),
    .MAX_ATTEMPTS  (MAXA),
    .BACKOFF_LIMIT (BLIM),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_beat    (tx_beat),
    .tx_last    (tx_last),
    .collision  (collision),
    .replayable (replayable),
    .replay     (replay),
    .done       (done),
    .hold       (hold),
    .jam        (jam),
    .drop       (drop),
    .tx_ok      (tx_ok),
    .tx_abort   (tx_abort),
    .late_col   (late_col),
    .attempts   (attempts),
    .dbg_state  (dbg_state)
  );

  // PRNG reference: polynomial division step, reseeded whenever reset is seen.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= m_lfsr[0] ? ({1'b0, m_lfsr[15:1]} ^ POLY) : {1'b0, m_lfsr[15:1]};
  end

  task automatic check_out(input string nm);
    logic [12:0] e, got;
    e   = exp_q.pop_front();
    got = {replay, done, hold, jam, drop, tx_ok, tx_abort, late_col, attempts};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s @%0t: got flags=%b att=%0d, want flags=%b att=%0d",
               nm, $time, got[12:5], got[4:0], e[12:5], e[4:0]);
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, check outputs after the next rising edge.
  task automatic step(input logic b, input logic l, input logic c, input logic rp,
                      input logic [7:0] f, input int a, input string nm);
    tx_beat = b; tx_last = l; collision = c; replayable = rp;
    exp_q.push_back({f, 5'(a)});
    @(negedge clk);
    check_out(nm);
  endtask

  // Jam then backoff after a retryable collision; slot count drawn from the reference PRNG.
  task automatic jam_backoff(input int att);
    int k;
    logic [15:0] r;
    repeat (JAMC - 1) step(0, 0, 0, 1, F_HOLD | F_JAM, att, "jam");
    k = (att > BLIM) ? BLIM : att;
    r = m_lfsr & ((16'd1 << k) - 16'd1);
    if (r == 16'd0) begin
      step(0, 0, 0, 1, 8'h0, att, "bo_none");
    end else begin
      repeat (int'(r) * SLOT) step(0, 0, 0, 1, F_HOLD, att, "backoff");
      step(0, 0, 0, 1, 8'h0, att, "bo_end");
    end
  endtask

  // Whole-frame model: collides at col_beat on the first ncol attempts; replayable for beats < repl_lim.
  task automatic run_frame(input int len, input int ncol, input int col_beat, input int late_beat,
                           input int repl_lim, input int gap_pct);
    int att = 0;
    bit retry;
    logic rp;
    for (int tr = 0; tr <= MAXA; tr++) begin
      retry = 1'b0;
      for (int b = 0; b < len && !retry; b++) begin
        rp = (b < repl_lim);
        if (b > 0 && $urandom_range(99) < gap_pct) step(0, 0, 0, rp, 8'h0, att, "gap");
        if (tr < ncol && b == col_beat) begin
          att++;
          if (att < MAXA) begin
            step(1, b == len - 1, 1, 1, F_REPLAY | F_HOLD | F_JAM, att, "collide");
            jam_backoff(att);
            retry = 1'b1;
          end else begin
            step(1, 0, 1, 1, F_DONE | F_ABORT | F_HOLD | F_JAM, att, "abort");
            repeat (JAMC - 1) step(0, 0, 0, 1, F_HOLD | F_JAM, att, "abort_jam");
            step(0, 0, 0, 0, F_DROP, att, "abort_drop");
            for (int d = b + 1; d < len; d++) begin
              if (d == len - 1) step(1, 1, 0, 0, 8'h0, 0, "drop_last");
              else              step(1, 0, 0, 0, F_DROP, att, "drop_beat");
            end
            return;
          end
        end else if (b == late_beat) begin
          step(1, 0, 1, 0, F_LATE, att, "late_col");
        end else if (b == len - 1) begin
          step(1, 1, 0, rp, F_DONE | F_OK, 0, "last");
          return;
        end else begin
          step(1, 0, 0, rp, 8'h0, att, "beat");
        end
      end
    end
  endtask

  typedef struct {
    logic       beat, last, col, repl;
    logic [7:0] flags;
    int         att;
    string      name;
  } vec_t;

  initial begin
    vec_t vt[9];
    int   att;
    logic [15:0] r;
    int   len, lim, ncol, cb, lb;

    rst = 1'b1; tx_beat = 0; tx_last = 0; collision = 0; replayable = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({replay, done, hold, jam, drop, tx_ok, tx_abort, late_col, attempts} !== 13'd0 ||
        dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %b state=%0d, want all zero in IDLE",
               {replay, done, hold, jam, drop, tx_ok, tx_abort, late_col, attempts}, dbg_state);
    end
    rst = 1'b0;

    vt[0] = '{1, 1, 0, 1, F_DONE | F_OK, 0, "idle_single_beat"};
    vt[1] = '{0, 0, 0, 1, 8'h0,          0, "idle_quiet"};
    vt[2] = '{0, 0, 1, 1, 8'h0,          0, "idle_col_ignored"};
    vt[3] = '{1, 0, 0, 1, 8'h0,          0, "first_beat"};
    vt[4] = '{1, 0, 1, 0, F_LATE,        0, "late_col"};
    vt[5] = '{0, 0, 1, 0, F_LATE,        0, "late_col_gap"};
    vt[6] = '{0, 0, 0, 0, 8'h0,          0, "tx_gap"};
    vt[7] = '{1, 1, 0, 0, F_DONE | F_OK, 0, "tx_last"};
    vt[8] = '{0, 0, 0, 0, 8'h0,          0, "back_idle"};
    for (int i = 0; i < 9; i++)
      step(vt[i].beat, vt[i].last, vt[i].col, vt[i].repl, vt[i].flags, vt[i].att, vt[i].name);

    run_frame(60, 0, 0, -1, 60, 0);     // clean 60-beat frame
    run_frame(60, 1, 10, -1, 60, 0);    // single collision at beat 10, replay from beat 0
    run_frame(20, 16, 5, -1, 20, 0);    // sixteen collisions: abort then drop to the end
    step(0, 0, 0, 0, 8'h0, 0, "after_abort");
    run_frame(70, 0, 0, 60, 60, 0);     // late collision once replayable has fallen
    run_frame(8, 1, 7, -1, 8, 0);       // collision on the last beat wins over tx_ok

    // Reset asserted while holding off in BACKOFF.
    step(1, 0, 0, 1, 8'h0, 0, "rb_first");
    att = 0;
    r   = 16'd0;
    while (r == 16'd0 && att < 10) begin
      att++;
      step(1, 0, 1, 1, F_REPLAY | F_HOLD | F_JAM, att, "rb_col");
      repeat (JAMC - 1) step(0, 0, 0, 1, F_HOLD | F_JAM, att, "rb_jam");
      r = m_lfsr & ((16'd1 << att) - 16'd1);
      if (r == 16'd0) step(0, 0, 0, 1, 8'h0, att, "rb_bo_none");
    end
    if (r != 16'd0) begin
      step(0, 0, 0, 1, F_HOLD, att, "rb_backoff");
      step(0, 0, 0, 1, F_HOLD, att, "rb_backoff2");
    end
    tx_beat = 0; collision = 0; replayable = 0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({replay, done, hold, jam, drop, tx_ok, tx_abort, late_col, attempts} !== 13'd0 ||
        dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_in_backoff: got %b state=%0d, want all zero in IDLE",
               {replay, done, hold, jam, drop, tx_ok, tx_abort, late_col, attempts}, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, 8'h0, 0, "post_rst");
    run_frame(12, 2, 3, -1, 12, 0);     // backoff lengths depend on a reseeded PRNG

    for (int n = 0; n < 40; n++) begin
      len  = $urandom_range(10, 3);
      lim  = $urandom_range(len, 2);
      ncol = $urandom_range(3, 0);
      cb   = $urandom_range(lim - 1, 1);
      lb   = (lim <= len - 2 && $urandom_range(1, 0) == 1) ? $urandom_range(len - 2, lim) : -1;
      run_frame(len, ncol, cb, lb, lim, 20);
      if ($urandom_range(1, 0) == 1) step(0, 0, 0, 0, 8'h0, 0, "rand_idle");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
